// File: rtl/lsu_ctrl_pkg.sv
// Shared LSU definitions: memory function/type codes, widths, FSM state encoding
// and helpers for normalising access types and detecting misaligned accesses.
package lsu_ctrl_pkg;

  localparam int RV_BIT_NUM      = 32;
  localparam int MEM_FCN_BIT_NUM = 1;
  localparam int MEM_TYP_BIT_NUM = 3;

  localparam logic [MEM_FCN_BIT_NUM-1:0] M_XRD = 1'b0;
  localparam logic [MEM_FCN_BIT_NUM-1:0] M_XWR = 1'b1;

  localparam logic [MEM_TYP_BIT_NUM-1:0] MT_B  = 3'd1;
  localparam logic [MEM_TYP_BIT_NUM-1:0] MT_H  = 3'd2;
  localparam logic [MEM_TYP_BIT_NUM-1:0] MT_W  = 3'd3;
  localparam logic [MEM_TYP_BIT_NUM-1:0] MT_BU = 3'd5;
  localparam logic [MEM_TYP_BIT_NUM-1:0] MT_HU = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Unknown type codes behave as full-word accesses.
  function automatic logic [MEM_TYP_BIT_NUM-1:0] norm_typ(input logic [MEM_TYP_BIT_NUM-1:0] typ);
    case (typ)
      MT_B, MT_H, MT_W, MT_BU, MT_HU: return typ;
      default:                        return MT_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [MEM_TYP_BIT_NUM-1:0] typ,
                                         input logic [1:0] addr_lo);
    logic [MEM_TYP_BIT_NUM-1:0] t;
    t = norm_typ(typ);
    case (t)
      MT_H, MT_HU: return addr_lo[0];
      MT_W:        return (addr_lo != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store data replication and load
// shift/extend. Misaligned H/W offsets are force-aligned down to their natural boundary.
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = RV_BIT_NUM
) (
  input  logic [MEM_TYP_BIT_NUM-1:0] typ,
  input  logic [1:0]                 addr_lo,
  input  logic [XLEN-1:0]            wdata,
  input  logic [XLEN-1:0]            rdata_word,
  output logic [3:0]                 be,
  output logic [XLEN-1:0]            wdata_rep,
  output logic [XLEN-1:0]            rdata_ext
);

  logic [MEM_TYP_BIT_NUM-1:0] t;
  logic [1:0]                 eff_lo;
  logic [XLEN-1:0]            shifted;

  always_comb begin
    t         = norm_typ(typ);
    eff_lo    = 2'b00;
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = '0;
    case (t)
      MT_B, MT_BU: eff_lo = addr_lo;
      MT_H, MT_HU: eff_lo = {addr_lo[1], 1'b0};
      default:     eff_lo = 2'b00;
    endcase
    shifted = rdata_word >> {eff_lo, 3'b000};
    case (t)
      MT_B: begin
        be        = 4'b0001 << eff_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      MT_BU: begin
        be        = 4'b0001 << eff_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      end
      MT_H: begin
        be        = 4'b0011 << eff_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      end
      MT_HU: begin
        be        = 4'b0011 << eff_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = shifted;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding memory transaction, IDLE->REQ->WAIT->DONE.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of force-aligning them.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = RV_BIT_NUM
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_val,
  input  logic [MEM_FCN_BIT_NUM-1:0] req_fcn,
  input  logic [MEM_TYP_BIT_NUM-1:0] req_typ,
  input  logic [XLEN-1:0]            req_addr,
  input  logic [XLEN-1:0]            req_wdata,
  output logic                       resp_valid,
  output logic [XLEN-1:0]            resp_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                       misalign,
`endif
  output logic                       mem_req_val,
  input  logic                       mem_req_rdy,
  output logic [XLEN-1:0]            mem_addr,
  output logic                       mem_wen,
  output logic [3:0]                 mem_be,
  output logic [XLEN-1:0]            mem_wdata,
  input  logic                       mem_resp_val,
  input  logic [XLEN-1:0]            mem_resp_data
);

  lsu_state_e                 state;
  logic [MEM_TYP_BIT_NUM-1:0] typ_q;
  logic [1:0]                 addr_lo_q;

  logic [MEM_TYP_BIT_NUM-1:0] sel_typ;
  logic [1:0]                 sel_lo;
  logic [3:0]                 be;
  logic [XLEN-1:0]            wdata_rep;
  logic [XLEN-1:0]            rdata_ext;

  // The single aligner sees the incoming request while idle and the latched one afterwards.
  assign sel_typ = (state == ST_IDLE) ? req_typ : typ_q;
  assign sel_lo  = (state == ST_IDLE) ? req_addr[1:0] : addr_lo_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .typ        (sel_typ),
    .addr_lo    (sel_lo),
    .wdata      (req_wdata),
    .rdata_word (mem_resp_data),
    .be         (be),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      typ_q       <= '0;
      addr_lo_q   <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      mem_req_val <= 1'b0;
      mem_addr    <= '0;
      mem_wen     <= 1'b0;
      mem_be      <= '0;
      mem_wdata   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_val) begin
            typ_q     <= req_typ;
            addr_lo_q <= req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
            if (is_misaligned(req_typ, req_addr[1:0])) begin
              state      <= ST_DONE;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              misalign   <= 1'b1;
            end else
`endif
            begin
              state       <= ST_REQ;
              mem_req_val <= 1'b1;
              mem_addr    <= {req_addr[XLEN-1:2], 2'b00};
              mem_wen     <= (req_fcn == M_XWR);
              mem_be      <= be;
              mem_wdata   <= wdata_rep;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_rdy) begin
            mem_req_val <= 1'b0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_resp_val) begin
            resp_rdata <= mem_wen ? '0 : rdata_ext;
            resp_valid <= 1'b1;
            state      <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
          misalign <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: expectations are queued when a request is driven
// and popped when resp_valid appears; a small memory model plays the bus side.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_val = 1'b0;
  logic [0:0]  req_fcn = M_XRD;
  logic [2:0]  req_typ = MT_W;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif
  logic        mem_req_val;
  logic        mem_req_rdy = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_resp_val = 1'b0;
  logic [31:0] mem_resp_data = '0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        wen;
    int          lat;
  } exp_t;

  exp_t sbQueue[$];
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_val       (req_val),
    .req_fcn       (req_fcn),
    .req_typ       (req_typ),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign      (misalign),
`endif
    .mem_req_val   (mem_req_val),
    .mem_req_rdy   (mem_req_rdy),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_resp_val  (mem_resp_val),
    .mem_resp_data (mem_resp_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic exp_t buildExpect(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [31:0] word,
                                       input int rdyDelay, input int respDelay);
    exp_t e;
    logic [2:0]  t;
    logic [1:0]  off;
    logic [7:0]  b;
    logic [15:0] h;
    t = (typ inside {MT_B, MT_H, MT_W, MT_BU, MT_HU}) ? typ : MT_W;
    case (t)
      MT_B, MT_BU: off = addr[1:0];
      MT_H, MT_HU: off = {addr[1], 1'b0};
      default:     off = 2'b00;
    endcase
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    e.addr = {addr[31:2], 2'b00};
    e.wen  = (fcn == M_XWR);
    e.lat  = 3 + rdyDelay + respDelay;
    case (t)
      MT_B, MT_BU: begin
        case (off)
          2'd0:    e.be = 4'b0001;
          2'd1:    e.be = 4'b0010;
          2'd2:    e.be = 4'b0100;
          default: e.be = 4'b1000;
        endcase
        e.wdata = {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
        e.rdata = (t == MT_B) ? {{24{b[7]}}, b} : {24'h0, b};
      end
      MT_H, MT_HU: begin
        e.be    = off[1] ? 4'b1100 : 4'b0011;
        e.wdata = {wdata[15:0], wdata[15:0]};
        e.rdata = (t == MT_H) ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: begin
        e.be    = 4'b1111;
        e.wdata = wdata;
        e.rdata = word;
      end
    endcase
    if (e.wen) e.rdata = '0;
    return e;
  endfunction

  task automatic applyStimulus(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] word,
                               input int rdyDelay, input int respDelay);
    exp_t e;
    exp_t f;
    int   cyc;
    bit   seen;
    e = buildExpect(fcn, typ, addr, wdata, word, rdyDelay, respDelay);
    sbQueue.push_back(e);
    @(negedge clk);
    req_val = 1'b1; req_fcn = fcn; req_typ = typ; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_val = 1'b0;
    cyc = 1;
    for (int i = 0; i <= rdyDelay; i++) begin
      checkOutput("memReqVal", {31'h0, mem_req_val}, 32'h1);
      checkOutput("memAddr", mem_addr, e.addr);
      checkOutput("memBe", {28'h0, mem_be}, {28'h0, e.be});
      checkOutput("memWdata", mem_wdata, e.wdata);
      checkOutput("memWen", {31'h0, mem_wen}, {31'h0, e.wen});
      checkOutput("respIdle", {31'h0, resp_valid}, 32'h0);
      mem_req_rdy   = (i == rdyDelay);
      mem_resp_val  = (i != rdyDelay);
      mem_resp_data = 32'hBAD0_BAD0;
      @(negedge clk);
      cyc++;
    end
    mem_req_rdy  = 1'b0;
    mem_resp_val = 1'b0;
    checkOutput("reqDropped", {31'h0, mem_req_val}, 32'h0);
    for (int i = 0; i < respDelay; i++) begin
      checkOutput("respEarly", {31'h0, resp_valid}, 32'h0);
      @(negedge clk);
      cyc++;
    end
    mem_resp_val  = 1'b1;
    mem_resp_data = word;
    @(negedge clk);
    cyc++;
    mem_resp_val  = 1'b0;
    mem_resp_data = $urandom;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      if (resp_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      checkOutput("respTimeout", 32'h0, 32'h1);
      void'(sbQueue.pop_front());
    end else begin
      f = sbQueue.pop_front();
      checkOutput("respRdata", resp_rdata, f.rdata);
      checkOutput("respLatency", cyc, f.lat);
      @(negedge clk);
      checkOutput("respPulse", {31'h0, resp_valid}, 32'h0);
      checkOutput("rdataHold", resp_rdata, f.rdata);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstRespValid", {31'h0, resp_valid}, 32'h0);
    checkOutput("rstMemReqVal", {31'h0, mem_req_val}, 32'h0);
    checkOutput("rstMemWen", {31'h0, mem_wen}, 32'h0);
    checkOutput("rstMemBe", {28'h0, mem_be}, 32'h0);
    checkOutput("rstMemAddr", mem_addr, 32'h0);
    checkOutput("rstMemWdata", mem_wdata, 32'h0);
    checkOutput("rstRespRdata", resp_rdata, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    checkOutput("rstMisalign", {31'h0, misalign}, 32'h0);
`endif
    rst_n = 1'b1;

    applyStimulus(M_XRD, MT_W,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 0);
    applyStimulus(M_XRD, MT_B,  32'h0000_0103, 32'h0,         32'h80FF_0000, 0, 0);
    applyStimulus(M_XRD, MT_BU, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0, 0);
    applyStimulus(M_XWR, MT_H,  32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 0, 0);
    applyStimulus(M_XRD, MT_HU, 32'h0000_0302, 32'h0,         32'h8001_7F00, 3, 2);
    applyStimulus(M_XRD, MT_H,  32'h0000_0300, 32'h0,         32'h1234_F00D, 1, 0);
    applyStimulus(M_XWR, MT_B,  32'h0000_0101, 32'h0000_00A5, 32'h0,         0, 1);
    applyStimulus(M_XRD, 3'd7,  32'h0000_0104, 32'h0,         32'h0BAD_F00D, 0, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    req_val = 1'b1; req_fcn = M_XRD; req_typ = MT_W; req_addr = 32'h0000_0101;
    @(negedge clk);
    req_val = 1'b0;
    checkOutput("trapMemReq", {31'h0, mem_req_val}, 32'h0);
    checkOutput("trapResp", {31'h0, resp_valid}, 32'h1);
    checkOutput("trapFlag", {31'h0, misalign}, 32'h1);
    checkOutput("trapRdata", resp_rdata, 32'h0);
    @(negedge clk);
    checkOutput("trapRespPulse", {31'h0, resp_valid}, 32'h0);
    checkOutput("trapFlagClear", {31'h0, misalign}, 32'h0);
`else
    applyStimulus(M_XRD, MT_W, 32'h0000_0101, 32'h0, 32'hCAFE_1234, 0, 0);
    applyStimulus(M_XRD, MT_H, 32'h0000_0103, 32'h0, 32'h9ABC_0011, 0, 0);
`endif

    // Reset while waiting for memory, then a stale response arrives.
    @(negedge clk);
    req_val = 1'b1; req_fcn = M_XRD; req_typ = MT_W; req_addr = 32'h0000_0400;
    @(negedge clk);
    req_val = 1'b0;
    mem_req_rdy = 1'b1;
    @(negedge clk);
    mem_req_rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rstWaitReqVal", {31'h0, mem_req_val}, 32'h0);
    checkOutput("rstWaitResp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_val = 1'b1;
    mem_resp_data = 32'h1111_2222;
    @(negedge clk);
    mem_resp_val = 1'b0;
    checkOutput("lateResp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    checkOutput("lateResp2", {31'h0, resp_valid}, 32'h0);
    checkOutput("lateRdata", resp_rdata, 32'h0);
    checkOutput("lateReqVal", {31'h0, mem_req_val}, 32'h0);

    for (int n = 0; n < 6; n++) begin
      logic [2:0]  t;
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0:       t = MT_B;
        1:       t = MT_BU;
        2:       t = MT_H;
        3:       t = MT_HU;
        default: t = MT_W;
      endcase
      a = $urandom & 32'h0000_FFFF;
      if (t == MT_H || t == MT_HU) a[0] = 1'b0;
      if (t == MT_W) a[1:0] = 2'b00;
      applyStimulus(($urandom_range(0, 1) == 1) ? M_XWR : M_XRD, t, a, $urandom, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
